register_file: RTL



---
 rtl/register_file.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/register_file.sv
// RV32I integer register file: 31 stored registers plus hardwired-zero x0, two async read ports, one write port.
// Optional write-through bypass on the read ports when compiled with REGISTER_FILE_BYPASS_EN.

// N-bit storage register with synchronous clear and load enable.
// Latency: value visible one cycle after the enabled edge.
// Backpressure: none, accepts a load on every enabled edge.
module register_file_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// 16:1 N-bit multiplexer over a flat bus, entry k at bits [k*N +: N].
// Latency: combinational.
// Backpressure: none.
module register_file_mux16 #(
    parameter int N = 32
) (
    input  logic [16*N-1:0] i_in,
    input  logic [3:0]      i_sel,
    output logic [N-1:0]    o_out
);
    assign o_out = i_in[int'(i_sel)*N +: N];
endmodule

// 32:1 read port: two 16:1 banks and a final 2:1 stage on the address MSB.
// Latency: combinational.
// Backpressure: none.
module register_file_rdport #(
    parameter int N = 32
) (
    input  logic [32*N-1:0] i_bank,
    input  logic [4:0]      i_addr,
    output logic [N-1:0]    o_data
);
    logic [N-1:0] w_lo;
    logic [N-1:0] w_hi;

    register_file_mux16 #(.N(N)) u_lo (
        .i_in  (i_bank[16*N-1:0]),
        .i_sel (i_addr[3:0]),
        .o_out (w_lo)
    );

    register_file_mux16 #(.N(N)) u_hi (
        .i_in  (i_bank[32*N-1:16*N]),
        .i_sel (i_addr[3:0]),
        .o_out (w_hi)
    );

    assign o_data = i_addr[4] ? w_hi : w_lo;
endmodule

// Register file top: 2 read ports (zero-cycle), 1 write port (visible next cycle).
// Latency: reads combinational; writes land on the rising edge.
// Backpressure: none, one write and two reads accepted every cycle.
module register_file #(
    parameter int N        = 32,
    parameter int NUM_REGS = 32,
    parameter int A        = $clog2(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [A-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [A-1:0] rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [A-1:0] rd_addr1,
    output logic [N-1:0] rd_data1
);
    logic [NUM_REGS-1:1]  w_we;
    logic [NUM_REGS*N-1:0] w_bank;
    logic [N-1:0]          w_rd0;
    logic [N-1:0]          w_rd1;

    // Decoder output 0 is never built: x0 has no storage to enable.
    always_comb begin
        w_we = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_we[i] = wr_ena && (wr_addr == A'(i));
        end
    end

    assign w_bank[N-1:0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
        register_file_reg #(.N(N)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_we[g]),
            .i_d  (wr_data),
            .o_q  (w_bank[g*N +: N])
        );
    end

    register_file_rdport #(.N(N)) u_rd0 (
        .i_bank (w_bank),
        .i_addr (rd_addr0),
        .o_data (w_rd0)
    );

    register_file_rdport #(.N(N)) u_rd1 (
        .i_bank (w_bank),
        .i_addr (rd_addr1),
        .o_data (w_rd1)
    );

`ifdef REGISTER_FILE_BYPASS_EN
    logic w_wr_live;
    logic w_byp0;
    logic w_byp1;

    // wr_addr != 0 also keeps a bypassed read of x0 from ever showing wr_data.
    assign w_wr_live = wr_ena && !rst && (wr_addr != '0);
    assign w_byp0    = w_wr_live && (rd_addr0 == wr_addr);
    assign w_byp1    = w_wr_live && (rd_addr1 == wr_addr);
    assign rd_data0  = w_byp0 ? wr_data : w_rd0;
    assign rd_data1  = w_byp1 ? wr_data : w_rd1;
`else
    assign rd_data0 = w_rd0;
    assign rd_data1 = w_rd1;
`endif
endmodule
